// File: rtl/ftq_pd_wb_writer_pkg.sv
// Shared sizes, branch-type encodings and the compressed predecode record
// written into the FTQ pd-mem.
package ftq_pd_wb_writer_pkg;
  localparam int FTQ_SIZE      = 64;
  localparam int PREDICT_WIDTH = 16;
  localparam int FTQ_IDX_W     = $clog2(FTQ_SIZE);
  localparam int OFFSET_W      = $clog2(PREDICT_WIDTH);
  localparam int VADDR_W       = 50;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BR   = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } brType_e;

  // jmpBits: [0] jalr, [1] call, [2] ret
  typedef struct packed {
    logic [PREDICT_WIDTH-1:0] brMask;
    logic                     jmpValid;
    logic [2:0]               jmpBits;
    logic [OFFSET_W-1:0]      jmpOffset;
    logic [VADDR_W-1:0]       jalTarget;
    logic [PREDICT_WIDTH-1:0] rvcMask;
  } pdEntry_t;

  typedef struct packed {
    logic [FTQ_IDX_W-1:0] ftqIdx;
    pdEntry_t             pd;
  } pdWrite_t;
endpackage

// File: rtl/ftq_pd_wb_writer_compress.sv
// Combinational compression of per-slot predecode flags into one pd-mem entry.
module ftq_pd_compress
  import ftq_pd_wb_writer_pkg::*;
(
  input  logic [PREDICT_WIDTH-1:0]   slotValid,
  input  logic [PREDICT_WIDTH-1:0]   isRVC,
  input  logic [PREDICT_WIDTH-1:0]   isCall,
  input  logic [PREDICT_WIDTH-1:0]   isRet,
  input  logic [2*PREDICT_WIDTH-1:0] brType,
  input  logic [VADDR_W-1:0]         jalTarget,
  output pdEntry_t                   entry
);
  always_comb begin
    entry           = '0;
    entry.rvcMask   = isRVC;
    entry.jalTarget = jalTarget;
    // Scan downward so the lowest qualifying jump slot wins.
    for (int i = PREDICT_WIDTH-1; i >= 0; i--) begin
      entry.brMask[i] = slotValid[i] & (brType[2*i +: 2] == BR_BR);
      if (slotValid[i] && brType[2*i+1]) begin
        entry.jmpValid  = 1'b1;
        entry.jmpOffset = OFFSET_W'(i);
        entry.jmpBits   = {isRet[i], isCall[i], brType[2*i]};
      end
    end
  end
endmodule

// File: rtl/ftq_pd_wb_writer.sv
// IFU predecode writeback: compress, buffer in a 2-entry FIFO, and drain into
// the pd-mem write port while tracking which FTQ entries were written.
module ftq_pd_wb_writer
  import ftq_pd_wb_writer_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [FTQ_IDX_W-1:0]       io_in_ftqIdx,
  input  logic [PREDICT_WIDTH-1:0]   io_in_slotValid,
  input  logic [PREDICT_WIDTH-1:0]   io_in_isRVC,
  input  logic [PREDICT_WIDTH-1:0]   io_in_isCall,
  input  logic [PREDICT_WIDTH-1:0]   io_in_isRet,
  input  logic [2*PREDICT_WIDTH-1:0] io_in_brType,
  input  logic [VADDR_W-1:0]         io_in_jalTarget,
  input  logic                       io_flush,
  input  logic                       io_wgrant,
  output logic                       io_wen_0,
  output logic [FTQ_IDX_W-1:0]       io_waddr_0,
  output logic io_wdata_0_brMask_0,  output logic io_wdata_0_brMask_1,
  output logic io_wdata_0_brMask_2,  output logic io_wdata_0_brMask_3,
  output logic io_wdata_0_brMask_4,  output logic io_wdata_0_brMask_5,
  output logic io_wdata_0_brMask_6,  output logic io_wdata_0_brMask_7,
  output logic io_wdata_0_brMask_8,  output logic io_wdata_0_brMask_9,
  output logic io_wdata_0_brMask_10, output logic io_wdata_0_brMask_11,
  output logic io_wdata_0_brMask_12, output logic io_wdata_0_brMask_13,
  output logic io_wdata_0_brMask_14, output logic io_wdata_0_brMask_15,
  output logic io_wdata_0_jmpInfo_valid,
  output logic io_wdata_0_jmpInfo_bits_0,
  output logic io_wdata_0_jmpInfo_bits_1,
  output logic io_wdata_0_jmpInfo_bits_2,
  output logic [OFFSET_W-1:0] io_wdata_0_jmpOffset,
  output logic [VADDR_W-1:0]  io_wdata_0_jalTarget,
  output logic io_wdata_0_rvcMask_0,  output logic io_wdata_0_rvcMask_1,
  output logic io_wdata_0_rvcMask_2,  output logic io_wdata_0_rvcMask_3,
  output logic io_wdata_0_rvcMask_4,  output logic io_wdata_0_rvcMask_5,
  output logic io_wdata_0_rvcMask_6,  output logic io_wdata_0_rvcMask_7,
  output logic io_wdata_0_rvcMask_8,  output logic io_wdata_0_rvcMask_9,
  output logic io_wdata_0_rvcMask_10, output logic io_wdata_0_rvcMask_11,
  output logic io_wdata_0_rvcMask_12, output logic io_wdata_0_rvcMask_13,
  output logic io_wdata_0_rvcMask_14, output logic io_wdata_0_rvcMask_15,
  output logic [FTQ_SIZE-1:0] io_written,
  output logic                io_dupWrite
);
  pdEntry_t   inEntry;
  pdEntry_t   wData;
  pdWrite_t   mem [2];
  pdWrite_t   head;
  logic [1:0] count;
  logic       wrPtr, rdPtr;
  logic       pop, push;

  ftq_pd_compress uCompress (
    .slotValid (io_in_slotValid),
    .isRVC     (io_in_isRVC),
    .isCall    (io_in_isCall),
    .isRet     (io_in_isRet),
    .brType    (io_in_brType),
    .jalTarget (io_in_jalTarget),
    .entry     (inEntry)
  );

  assign head        = mem[rdPtr];
  assign pop         = (count != 2'd0) && io_wgrant && !io_flush;
  assign io_in_ready = (count != 2'd2) || pop;
  assign push        = io_in_valid && io_in_ready && !io_flush;

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= '{ftqIdx: io_in_ftqIdx, pd: inEntry};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= 2'd0;
      wrPtr       <= 1'b0;
      rdPtr       <= 1'b0;
      io_wen_0    <= 1'b0;
      io_waddr_0  <= '0;
      wData       <= '0;
      io_written  <= '0;
      io_dupWrite <= 1'b0;
    end else begin
      io_wen_0    <= pop;
      io_dupWrite <= pop && io_written[head.ftqIdx];
      if (pop) begin
        io_waddr_0 <= head.ftqIdx;
        wData      <= head.pd;
      end
      if (io_flush) begin
        count      <= 2'd0;
        wrPtr      <= 1'b0;
        rdPtr      <= 1'b0;
        io_written <= '0;
      end else begin
        if (push) wrPtr <= ~wrPtr;
        if (pop) begin
          rdPtr                   <= ~rdPtr;
          io_written[head.ftqIdx] <= 1'b1;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign io_wdata_0_jmpInfo_valid  = wData.jmpValid;
  assign io_wdata_0_jmpInfo_bits_0 = wData.jmpBits[0];
  assign io_wdata_0_jmpInfo_bits_1 = wData.jmpBits[1];
  assign io_wdata_0_jmpInfo_bits_2 = wData.jmpBits[2];
  assign io_wdata_0_jmpOffset      = wData.jmpOffset;
  assign io_wdata_0_jalTarget      = wData.jalTarget;

  assign io_wdata_0_brMask_0  = wData.brMask[0];  assign io_wdata_0_brMask_1  = wData.brMask[1];
  assign io_wdata_0_brMask_2  = wData.brMask[2];  assign io_wdata_0_brMask_3  = wData.brMask[3];
  assign io_wdata_0_brMask_4  = wData.brMask[4];  assign io_wdata_0_brMask_5  = wData.brMask[5];
  assign io_wdata_0_brMask_6  = wData.brMask[6];  assign io_wdata_0_brMask_7  = wData.brMask[7];
  assign io_wdata_0_brMask_8  = wData.brMask[8];  assign io_wdata_0_brMask_9  = wData.brMask[9];
  assign io_wdata_0_brMask_10 = wData.brMask[10]; assign io_wdata_0_brMask_11 = wData.brMask[11];
  assign io_wdata_0_brMask_12 = wData.brMask[12]; assign io_wdata_0_brMask_13 = wData.brMask[13];
  assign io_wdata_0_brMask_14 = wData.brMask[14]; assign io_wdata_0_brMask_15 = wData.brMask[15];

  assign io_wdata_0_rvcMask_0  = wData.rvcMask[0];  assign io_wdata_0_rvcMask_1  = wData.rvcMask[1];
  assign io_wdata_0_rvcMask_2  = wData.rvcMask[2];  assign io_wdata_0_rvcMask_3  = wData.rvcMask[3];
  assign io_wdata_0_rvcMask_4  = wData.rvcMask[4];  assign io_wdata_0_rvcMask_5  = wData.rvcMask[5];
  assign io_wdata_0_rvcMask_6  = wData.rvcMask[6];  assign io_wdata_0_rvcMask_7  = wData.rvcMask[7];
  assign io_wdata_0_rvcMask_8  = wData.rvcMask[8];  assign io_wdata_0_rvcMask_9  = wData.rvcMask[9];
  assign io_wdata_0_rvcMask_10 = wData.rvcMask[10]; assign io_wdata_0_rvcMask_11 = wData.rvcMask[11];
  assign io_wdata_0_rvcMask_12 = wData.rvcMask[12]; assign io_wdata_0_rvcMask_13 = wData.rvcMask[13];
  assign io_wdata_0_rvcMask_14 = wData.rvcMask[14]; assign io_wdata_0_rvcMask_15 = wData.rvcMask[15];
endmodule

// File: tb/tb_ftq_pd_wb_writer.sv
// Scoreboard bench for ftq_pd_wb_writer: a queue-level reference model predicts
// every pd-mem write, and a negedge monitor checks them as they appear.
module tb_ftq_pd_wb_writer;
  import ftq_pd_wb_writer_pkg::*;

  typedef struct {
    pdWrite_t w;
    logic     dup;
  } expWrite_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [5:0]  inIdx = '0;
  logic [15:0] inSv = '0, inRvc = '0, inCall = '0, inRet = '0;
  logic [31:0] inBt = '0;
  logic [49:0] inJt = '0;
  logic        flush = 1'b0, grant = 1'b0;
  logic        wen, dup;
  logic [5:0]  waddr;
  logic [15:0] oBr, oRvc;
  logic        oJv;
  logic [2:0]  oJb;
  logic [3:0]  oJo;
  logic [49:0] oJt;
  logic [63:0] written;
  pdEntry_t    dutPd;

  int tests = 0;
  int fails = 0;

  pdWrite_t    pend [$];
  expWrite_t   expQ [$];
  logic [63:0] writtenM = '0;

  assign dutPd = {oBr, oJv, oJb, oJo, oJt, oRvc};

  always #5 clock = ~clock;

  ftq_pd_wb_writer dut (
    .clock(clock), .reset(reset),
    .io_in_valid(inValid), .io_in_ready(inReady), .io_in_ftqIdx(inIdx),
    .io_in_slotValid(inSv), .io_in_isRVC(inRvc), .io_in_isCall(inCall), .io_in_isRet(inRet),
    .io_in_brType(inBt), .io_in_jalTarget(inJt),
    .io_flush(flush), .io_wgrant(grant),
    .io_wen_0(wen), .io_waddr_0(waddr),
    .io_wdata_0_brMask_0(oBr[0]),   .io_wdata_0_brMask_1(oBr[1]),
    .io_wdata_0_brMask_2(oBr[2]),   .io_wdata_0_brMask_3(oBr[3]),
    .io_wdata_0_brMask_4(oBr[4]),   .io_wdata_0_brMask_5(oBr[5]),
    .io_wdata_0_brMask_6(oBr[6]),   .io_wdata_0_brMask_7(oBr[7]),
    .io_wdata_0_brMask_8(oBr[8]),   .io_wdata_0_brMask_9(oBr[9]),
    .io_wdata_0_brMask_10(oBr[10]), .io_wdata_0_brMask_11(oBr[11]),
    .io_wdata_0_brMask_12(oBr[12]), .io_wdata_0_brMask_13(oBr[13]),
    .io_wdata_0_brMask_14(oBr[14]), .io_wdata_0_brMask_15(oBr[15]),
    .io_wdata_0_jmpInfo_valid(oJv),
    .io_wdata_0_jmpInfo_bits_0(oJb[0]), .io_wdata_0_jmpInfo_bits_1(oJb[1]),
    .io_wdata_0_jmpInfo_bits_2(oJb[2]),
    .io_wdata_0_jmpOffset(oJo), .io_wdata_0_jalTarget(oJt),
    .io_wdata_0_rvcMask_0(oRvc[0]),   .io_wdata_0_rvcMask_1(oRvc[1]),
    .io_wdata_0_rvcMask_2(oRvc[2]),   .io_wdata_0_rvcMask_3(oRvc[3]),
    .io_wdata_0_rvcMask_4(oRvc[4]),   .io_wdata_0_rvcMask_5(oRvc[5]),
    .io_wdata_0_rvcMask_6(oRvc[6]),   .io_wdata_0_rvcMask_7(oRvc[7]),
    .io_wdata_0_rvcMask_8(oRvc[8]),   .io_wdata_0_rvcMask_9(oRvc[9]),
    .io_wdata_0_rvcMask_10(oRvc[10]), .io_wdata_0_rvcMask_11(oRvc[11]),
    .io_wdata_0_rvcMask_12(oRvc[12]), .io_wdata_0_rvcMask_13(oRvc[13]),
    .io_wdata_0_rvcMask_14(oRvc[14]), .io_wdata_0_rvcMask_15(oRvc[15]),
    .io_written(written), .io_dupWrite(dup)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic pdEntry_t refCompress(input logic [15:0] sv, rvc, call, ret,
                                           input logic [31:0] bt, input logic [49:0] jt);
    pdEntry_t e;
    int j;
    e = '0;
    j = -1;
    for (int i = 0; i < 16; i++) begin
      if (sv[i] && bt[2*i +: 2] == 2'd1) e.brMask[i] = 1'b1;
      if (j < 0 && sv[i] && (bt[2*i +: 2] == 2'd2 || bt[2*i +: 2] == 2'd3)) j = i;
    end
    e.rvcMask   = rvc;
    e.jalTarget = jt;
    if (j >= 0) begin
      e.jmpValid  = 1'b1;
      e.jmpOffset = 4'(j);
      e.jmpBits   = {ret[j], call[j], bt[2*j +: 2] == 2'd3};
    end
    return e;
  endfunction

  // Called at posedge+2; returns at the following posedge+2.
  task automatic step(input logic g, input logic f);
    logic popE, readyE, accE;
    pdWrite_t w, nw;
    grant = g;
    flush = f;
    #1;
    popE   = (pend.size() > 0) && g && !f;
    readyE = (pend.size() < 2) || popE;
    chk("in_ready", inReady, readyE);
    accE = inValid && readyE && !f;
    nw.ftqIdx = inIdx;
    nw.pd     = refCompress(inSv, inRvc, inCall, inRet, inBt, inJt);
    @(posedge clock);
    if (f) begin
      pend.delete();
      writtenM = '0;
    end else begin
      if (popE) begin
        w = pend.pop_front();
        expQ.push_back('{w: w, dup: writtenM[w.ftqIdx]});
        writtenM[w.ftqIdx] = 1'b1;
      end
      if (accE) pend.push_back(nw);
    end
    #2;
  endtask

  task automatic setIn(input logic v, input logic [5:0] idx, input logic [15:0] sv,
                       input logic [31:0] bt, input logic [15:0] call, input logic [15:0] ret);
    inValid = v;
    inIdx   = idx;
    inSv    = sv;
    inBt    = bt;
    inCall  = call;
    inRet   = ret;
    inRvc   = 16'($urandom);
    inJt    = {18'($urandom), 32'($urandom)};
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_wen"}, wen, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wdata"}, dutPd, 0);
    chk({tag, "_written"}, written, 0);
    chk({tag, "_dup"}, dup, 0);
    chk({tag, "_ready"}, inReady, 1);
  endtask

  initial begin : monitor
    expWrite_t e;
    forever begin
      @(negedge clock);
      chk("written_map", written, writtenM);
      if (wen) begin
        if (expQ.size() == 0) begin
          chk("unexpected_wen", wen, 0);
        end else begin
          e = expQ.pop_front();
          chk("waddr", waddr, e.w.ftqIdx);
          chk("wdata", dutPd, e.w.pd);
          chk("dupWrite", dup, e.dup);
        end
      end else begin
        chk("dup_without_wen", dup, 0);
      end
    end
  end

  initial begin : stimulus
    @(posedge clock);
    #2;
    chkResetOutputs("reset");
    reset = 1'b1;

    // Branch at slots 1,4; jalr+ret at 6; jal at 9 (later, ignored).
    setIn(1, 6'd5, 16'h0252, 32'h0008_3000 | 32'h0000_0104, 16'h0000, 16'h0040);
    step(1, 0);
    inValid = 0;
    step(1, 0);
    chk("d1_wen", wen, 1);
    chk("d1_waddr", waddr, 5);
    chk("d1_brMask", oBr, 16'h0012);
    chk("d1_jmpValid", oJv, 1);
    chk("d1_jmpOffset", oJo, 6);
    chk("d1_jmpBits", oJb, 3'b101);

    // Slot 3 branch, slot 5 jal but not slot-valid: no jump.
    setIn(1, 6'd9, 16'h0008, 32'h0000_0840, 16'hffff, 16'hffff);
    step(1, 0);
    inValid = 0;
    step(1, 0);
    chk("d2_wen", wen, 1);
    chk("d2_brMask", oBr, 16'h0008);
    chk("d2_jmpValid", oJv, 0);
    chk("d2_jmpOffset", oJo, 0);
    chk("d2_jmpBits", oJb, 0);

    // Back-pressure: three valids with no grant, third stalls until first pop.
    setIn(1, 6'd0, 16'h0001, 32'h1, 0, 0); step(0, 0);
    setIn(1, 6'd1, 16'h0002, 32'h4, 0, 0); step(0, 0);
    setIn(1, 6'd2, 16'h0004, 32'h10, 0, 0);
    step(0, 0);
    chk("d3_ready_low", inReady, 0);
    step(1, 0);
    inValid = 0;
    repeat (4) step(1, 0);

    // Same index written twice.
    setIn(1, 6'd7, 16'h0, 32'h0, 0, 0); step(1, 0);
    setIn(1, 6'd7, 16'h0100, 32'h0003_0000, 0, 0); step(1, 0);
    inValid = 0;
    repeat (3) step(1, 0);
    chk("d4_written7", written[7], 1);

    // Flush with two queued and a same-cycle valid.
    setIn(1, 6'd10, 16'h1, 32'h1, 0, 0); step(0, 0);
    setIn(1, 6'd11, 16'h1, 32'h1, 0, 0); step(0, 0);
    setIn(1, 6'd12, 16'h1, 32'h1, 0, 0); step(1, 1);
    chk("d5_wen_after_flush", wen, 0);
    chk("d5_written_clear", written, 0);
    inValid = 0;
    repeat (3) step(1, 0);

    // Reset with two queued entries.
    setIn(1, 6'd20, 16'h1, 32'h1, 0, 0); step(0, 0);
    setIn(1, 6'd21, 16'h1, 32'h1, 0, 0); step(0, 0);
    inValid = 0;
    reset = 1'b0;
    #1;
    pend.delete();
    expQ.delete();
    writtenM = '0;
    chkResetOutputs("midreset");
    @(posedge clock);
    #2;
    reset = 1'b1;
    repeat (3) step(1, 0);

    // Randomized traffic; small index range exercises duplicate writes.
    for (int n = 0; n < 500; n++) begin
      setIn($urandom_range(0, 9) < 7, 6'($urandom_range(0, 7)), 16'($urandom), 32'($urandom),
            16'($urandom), 16'($urandom));
      step($urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end
    inValid = 0;
    repeat (5) step(1, 0);
    chk("drain_expq", expQ.size(), 0);
    chk("drain_pend", pend.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
